pia_multi: RTL and testbench

Parametrised peripheral interface adapter: NPORTS independent I/O channels of WIDTH bits. Each channel has a data direction register, an output register, a control register, edge-detected C1/C2 interrupt inputs and a C2 line that works as an input or as a handshake/pulse/static output. It sits on the CPU bus next to the existing 6820-style PIA and replaces it where more channels, wider ports or hardware handshaking are needed.

---
 rtl/pia_pkg.sv | 28 ++
 rtl/pia_if.sv | 15 +
 rtl/pia_port.sv | 191 +++++++++++++++++++
 rtl/pia_multi.sv | 86 ++++++++
 tb/tb_pia_multi.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pia_pkg.sv
// Shared definitions for the pia_multi peripheral adapter: control-register bit
// positions, C2 output modes, register-select decode and the edge-match helper.
package pia_pkg;

   localparam int CR_C1_EN    = 0;
   localparam int CR_C1_EDGE  = 1;
   localparam int CR_DATA_SEL = 2;
   localparam int CR_C2_EN    = 3;
   localparam int CR_C2_EDGE  = 4;
   localparam int CR_C2_OUT   = 5;
   localparam int CR_IRQ2     = 6;
   localparam int CR_IRQ1     = 7;

   localparam logic RS_DATA = 1'b0;
   localparam logic RS_CTRL = 1'b1;

   typedef enum logic [1:0] {
      C2_HANDSHAKE = 2'b00,
      C2_PULSE     = 2'b01,
      C2_LOW       = 2'b10,
      C2_HIGH      = 2'b11
   } c2_mode_e;

   function automatic logic edge_hit(input logic cur, input logic prev, input logic rise);
      return rise ? (cur & ~prev) : (~cur & prev);
   endfunction

endpackage

// File: rtl/pia_if.sv
// CPU-side bus of pia_multi: chip select, address, direction, write data and
// registered read data.
interface pia_bus_if #(
   parameter int WIDTH = 8,
   parameter int AW    = 2
);
   logic             cs;
   logic [AW-1:0]    addr;
   logic             rw;
   logic [WIDTH-1:0] DI;
   logic [WIDTH-1:0] DO;

   modport master (output cs, addr, rw, DI, input DO);
   modport slave  (input cs, addr, rw, DI, output DO);
endinterface

// File: rtl/pia_port.sv
// One pia_multi channel: DDR, output register, control register, input
// synchroniser (two stages when PIA_SYNC_EN is defined), edge detect and C2 FSM.
module pia_port
   import pia_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int IS_ODD = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   input  logic             rw,
   input  logic             rs,
   input  logic [WIDTH-1:0] di,
   input  logic [WIDTH-1:0] pi,
   input  logic             c1,
   input  logic             c2i,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] po,
   output logic [WIDTH-1:0] po_oe,
   output logic             c2o,
   output logic             c2_oe,
   output logic             irq_n
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_HS_WAIT = 2'd1;
   localparam logic [1:0] ST_PULSE   = 2'd2;
   localparam int         SW         = WIDTH + 2;

   logic [WIDTH-1:0] ddr_q, ddr_d, or_q, or_d;
   logic [7:0]       cr_q, cr_d;
   logic [SW-1:0]    sync_q, sync_d;
   logic [1:0]       prev_q, prev_d;
   logic             c1_det_q, c1_det_d;
   logic [1:0]       st_q, st_d;
   logic             c2o_q, c2o_d;

   logic [WIDTH-1:0] pin_s;
   logic             c1_s, c2_s, c1_hit_s, c2_hit_s;
   logic             wr_s, rd_s, data_sel_s, strobe_s;

`ifdef PIA_SYNC_EN
   logic [SW-1:0] meta_q, meta_d;
   assign meta_d = {c2i, c1, pi};
   assign sync_d = meta_q;
`else
   assign sync_d = {c2i, c1, pi};
`endif

   assign pin_s      = sync_q[WIDTH-1:0];
   assign c1_s       = sync_q[WIDTH];
   assign c2_s       = sync_q[WIDTH+1];
   assign prev_d     = {c2_s, c1_s};
   assign c1_hit_s   = edge_hit(c1_s, prev_q[0], cr_q[CR_C1_EDGE]);
   assign c2_hit_s   = ~cr_q[CR_C2_OUT] & edge_hit(c2_s, prev_q[1], cr_q[CR_C2_EDGE]);
   assign c1_det_d   = c1_hit_s;
   assign wr_s       = sel & ~rw;
   assign rd_s       = sel & rw;
   assign data_sel_s = (rs == RS_DATA) & cr_q[CR_DATA_SEL];
   assign strobe_s   = data_sel_s & ((IS_ODD != 0) ? wr_s : rd_s);

   // register writes; flag set takes priority over clear-by-read
   always_comb begin
      ddr_d = ddr_q;
      or_d  = or_q;
      cr_d  = cr_q;
      if (wr_s) begin
         if (rs == RS_CTRL) begin
            cr_d[5:0] = di[5:0];
         end else if (cr_q[CR_DATA_SEL]) begin
            or_d = di;
         end else begin
            ddr_d = di;
         end
      end else begin
         ddr_d = ddr_q;
      end
      cr_d[CR_IRQ1] = c1_hit_s | (cr_q[CR_IRQ1] & ~(rd_s & data_sel_s));
      cr_d[CR_IRQ2] = c2_hit_s | (cr_q[CR_IRQ2] & ~(rd_s & data_sel_s));
   end

   // read value presented to the top-level DO mux
   always_comb begin
      rd_data = '0;
      if (rs == RS_CTRL) begin
         rd_data[7:0] = cr_q;
      end else if (cr_q[CR_DATA_SEL]) begin
         rd_data = (ddr_q & or_q) | (~ddr_q & pin_s);
      end else begin
         rd_data = ddr_q;
      end
   end

   // C2 output: handshake waits for C1, pulse lasts one cycle, static follows CR[3]
   always_comb begin
      st_d  = st_q;
      c2o_d = 1'b1;
      if (!cr_q[CR_C2_OUT]) begin
         st_d  = ST_IDLE;
         c2o_d = 1'b1;
      end else begin
         case (c2_mode_e'(cr_q[CR_C2_EDGE:CR_C2_EN]))
            C2_HANDSHAKE: begin
               case (st_q)
                  ST_IDLE: begin
                     if (strobe_s) begin
                        st_d  = ST_HS_WAIT;
                        c2o_d = 1'b0;
                     end else begin
                        st_d  = ST_IDLE;
                        c2o_d = 1'b1;
                     end
                  end
                  ST_HS_WAIT: begin
                     if (c1_det_q) begin
                        st_d  = ST_IDLE;
                        c2o_d = 1'b1;
                     end else begin
                        st_d  = ST_HS_WAIT;
                        c2o_d = 1'b0;
                     end
                  end
                  default: begin
                     st_d  = ST_IDLE;
                     c2o_d = 1'b1;
                  end
               endcase
            end
            C2_PULSE: begin
               if (strobe_s) begin
                  st_d  = ST_PULSE;
                  c2o_d = 1'b0;
               end else begin
                  st_d  = ST_IDLE;
                  c2o_d = 1'b1;
               end
            end
            C2_LOW: begin
               st_d  = ST_IDLE;
               c2o_d = 1'b0;
            end
            C2_HIGH: begin
               st_d  = ST_IDLE;
               c2o_d = 1'b1;
            end
            default: begin
               st_d  = ST_IDLE;
               c2o_d = 1'b1;
            end
         endcase
      end
   end

   // channel state; input stages reset to the idle-high level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ddr_q    <= '0;
         or_q     <= '0;
         cr_q     <= 8'h00;
         sync_q   <= '1;
`ifdef PIA_SYNC_EN
         meta_q   <= '1;
`endif
         prev_q   <= 2'b11;
         c1_det_q <= 1'b0;
         st_q     <= ST_IDLE;
         c2o_q    <= 1'b1;
      end else begin
         ddr_q    <= ddr_d;
         or_q     <= or_d;
         cr_q     <= cr_d;
         sync_q   <= sync_d;
`ifdef PIA_SYNC_EN
         meta_q   <= meta_d;
`endif
         prev_q   <= prev_d;
         c1_det_q <= c1_det_d;
         st_q     <= st_d;
         c2o_q    <= c2o_d;
      end
   end

   assign po    = or_q;
   assign po_oe = ddr_q;
   assign c2o   = c2o_q;
   assign c2_oe = cr_q[CR_C2_OUT];
   assign irq_n = ~((cr_q[CR_IRQ1] & cr_q[CR_C1_EN]) |
                    (cr_q[CR_IRQ2] & cr_q[CR_C2_EN] & ~cr_q[CR_C2_OUT]));

endmodule

// File: rtl/pia_multi.sv
// Multi-channel PIA: address decode, NPORTS pia_port instances and registered
// read-data mux. Define PIA_SYNC_EN for two-flop input synchronisers.
module pia_multi
   import pia_pkg::*;
#(
   parameter int NPORTS = 2,
   parameter int WIDTH  = 8,
   parameter int AW     = (($clog2(NPORTS) + 1) < 2) ? 2 : ($clog2(NPORTS) + 1)
) (
   input  logic                    enable,
   input  logic                    reset,
   pia_bus_if.slave                bus,
   input  logic [NPORTS*WIDTH-1:0] PI,
   output logic [NPORTS*WIDTH-1:0] PO,
   output logic [NPORTS*WIDTH-1:0] PO_OE,
   input  logic [NPORTS-1:0]       C1,
   input  logic [NPORTS-1:0]       C2I,
   output logic [NPORTS-1:0]       C2O,
   output logic [NPORTS-1:0]       C2_OE,
   output logic [NPORTS-1:0]       irq_n
);

   logic                          rs_s;
   logic [AW-2:0]                 ch_s;
   logic [NPORTS-1:0]             sel_s;
   logic [NPORTS-1:0][WIDTH-1:0]  port_rd_s;
   logic [WIDTH-1:0]              rd_sel_s;
   logic [WIDTH-1:0]              do_q, do_d;

   assign rs_s = bus.addr[0];
   assign ch_s = bus.addr[AW-1:1];

   for (genvar n = 0; n < NPORTS; n++) begin : g_port
      assign sel_s[n] = bus.cs & (int'(ch_s) == n);

      pia_port #(
         .WIDTH  (WIDTH),
         .IS_ODD (n % 2)
      ) u_port (
         .clk     (enable),
         .rst     (reset),
         .sel     (sel_s[n]),
         .rw      (bus.rw),
         .rs      (rs_s),
         .di      (bus.DI),
         .pi      (PI[n*WIDTH +: WIDTH]),
         .c1      (C1[n]),
         .c2i     (C2I[n]),
         .rd_data (port_rd_s[n]),
         .po      (PO[n*WIDTH +: WIDTH]),
         .po_oe   (PO_OE[n*WIDTH +: WIDTH]),
         .c2o     (C2O[n]),
         .c2_oe   (C2_OE[n]),
         .irq_n   (irq_n[n])
      );
   end

   // read mux; channels without a port read as zero
   always_comb begin
      rd_sel_s = '0;
      for (int n = 0; n < NPORTS; n++) begin
         if (int'(ch_s) == n) begin
            rd_sel_s = port_rd_s[n];
         end else begin
            rd_sel_s = rd_sel_s;
         end
      end
      if (bus.cs & bus.rw) begin
         do_d = rd_sel_s;
      end else begin
         do_d = do_q;
      end
   end

   // read data holds until the next read
   always_ff @(posedge enable or posedge reset) begin
      if (reset) begin
         do_q <= '0;
      end else begin
         do_q <= do_d;
      end
   end

   assign bus.DO = do_q;

endmodule

// File: tb/tb_pia_multi.sv
// Scoreboard bench for pia_multi (3 channels, so channel 3 is out of range).
module tb_pia_multi;
   localparam int NP = 3;
   localparam int W  = 8;
   localparam int AW = 3;
`ifdef PIA_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NP*W-1:0]   PI, PO, PO_OE;
   logic [NP-1:0]     C1, C2I, C2O, C2_OE, irq_n;

   pia_bus_if #(.WIDTH(W), .AW(AW)) bus ();

   pia_multi #(.NPORTS(NP), .WIDTH(W), .AW(AW)) dut (
      .enable (clk), .reset (rst), .bus (bus),
      .PI (PI), .PO (PO), .PO_OE (PO_OE),
      .C1 (C1), .C2I (C2I), .C2O (C2O), .C2_OE (C2_OE), .irq_n (irq_n)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   string        nm_q[$];
   logic         rd_seen = 1'b0;

   // behavioural register model: index 3 stands for the missing channel
   logic [7:0] m_ddr[4], m_or[4], m_cr[4], m_pin[4];

   always @(posedge clk) rd_seen <= bus.cs & bus.rw;

   always @(negedge clk) begin
      if (rd_seen) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read got=%h", bus.DO);
         end else begin
            logic [W-1:0] e;
            string        n;
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            if (bus.DO !== e) begin
               errors++;
               $display("FAIL %s got=%h expected=%h", n, bus.DO, e);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] e);
      checks++;
      if (act !== e) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", n, act, e);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_ddr[i] = 8'h00; m_or[i] = 8'h00; m_cr[i] = 8'h00;
      end
   endtask

   function automatic logic [7:0] model_rd(input int ch, input bit rs);
      if (ch >= NP) return 8'h00;
      if (rs) return m_cr[ch];
      if (m_cr[ch][2]) return (m_ddr[ch] & m_or[ch]) | (~m_ddr[ch] & m_pin[ch]);
      return m_ddr[ch];
   endfunction

   task automatic set_pins(input logic [NP*W-1:0] v);
      PI = v;
      for (int i = 0; i < NP; i++) m_pin[i] = v[i*W +: W];
   endtask

   task automatic do_wr(input int ch, input bit rs, input logic [7:0] v);
      if (ch < NP) begin
         if (rs) m_cr[ch][5:0] = v[5:0];
         else if (m_cr[ch][2]) m_or[ch] = v;
         else m_ddr[ch] = v;
      end
      bus.cs = 1'b1; bus.rw = 1'b0; bus.addr = {2'(ch), rs}; bus.DI = v;
      cyc();
      bus.cs = 1'b0;
   endtask

   task automatic do_rd(input int ch, input bit rs, input string n);
      exp_q.push_back(model_rd(ch, rs));
      nm_q.push_back(n);
      if (ch < NP && !rs && m_cr[ch][2]) m_cr[ch][7:6] = 2'b00;
      bus.cs = 1'b1; bus.rw = 1'b1; bus.addr = {2'(ch), rs};
      cyc();
      bus.cs = 1'b0;
   endtask

   initial begin
      bus.cs = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.DI = '0;
      C1 = 3'b111; C2I = 3'b111;
      set_pins(24'h995E3C);
      model_reset();
      idle(3);
      rst = 1'b0;

      chk("rst_c2o", C2O, 3'b111);
      chk("rst_irq_n", irq_n, 3'b111);
      chk("rst_po", PO, 24'h0);
      chk("rst_po_oe", PO_OE, 24'h0);
      chk("rst_c2_oe", C2_OE, 3'b000);
      do_rd(0, 1'b1, "rst_cr0");
      do_rd(0, 1'b0, "rst_ddr0");

      // DDR / data mix on channel 0
      do_wr(0, 1'b1, 8'h00);
      do_wr(0, 1'b0, 8'hF0);
      do_wr(0, 1'b1, 8'h04);
      do_wr(0, 1'b0, 8'hA5);
      chk("po0", PO[7:0], 8'hA5);
      chk("po_oe0", PO_OE[7:0], 8'hF0);
      do_rd(0, 1'b0, "data0_mix");
      do_rd(0, 1'b1, "cr0_04");
      do_wr(3, 1'b0, 8'hFF);
      do_rd(3, 1'b0, "oor_after_wr");

      // C1 rising-edge interrupt on channel 1
      do_wr(1, 1'b1, 8'h07);
      C1[1] = 1'b0;
      idle(4);
      do_rd(1, 1'b1, "cr1_noflag");
      chk("irq1_idle", irq_n[1], 1'b1);
      C1[1] = 1'b1;
      idle(LAT);
      chk("irq1_before_latency", irq_n[1], 1'b1);
      cyc();
      chk("irq1_set", irq_n[1], 1'b0);
      m_cr[1][7] = 1'b1;
      do_rd(1, 1'b1, "cr1_flag");
      do_rd(1, 1'b0, "data1_clear");
      chk("irq1_cleared", irq_n[1], 1'b1);
      C1[1] = 1'b0;
      idle(4);
      C1[1] = 1'b1;
      idle(LAT);
      do_rd(1, 1'b0, "data1_coincide");
      m_cr[1][7] = 1'b1;
      chk("irq1_set_wins", irq_n[1], 1'b0);
      do_rd(1, 1'b1, "cr1_kept");

      // handshake on even channel (read strobe)
      do_wr(0, 1'b1, 8'h24);
      idle(1);
      chk("hs0_idle", C2O[0], 1'b1);
      chk("hs0_oe", C2_OE[0], 1'b1);
      do_rd(0, 1'b0, "data0_hs");
      chk("hs0_low", C2O[0], 1'b0);
      idle(2);
      chk("hs0_hold", C2O[0], 1'b0);
      C1[0] = 1'b0;
      idle(LAT);
      chk("hs0_wait", C2O[0], 1'b0);
      cyc();
      chk("hs0_detect_edge", C2O[0], 1'b0);
      cyc();
      chk("hs0_release", C2O[0], 1'b1);
      m_cr[0][7] = 1'b1;
      do_rd(0, 1'b1, "cr0_hsflag");
      C1[0] = 1'b1;
      idle(3);

      // handshake on odd channel (write strobe)
      do_wr(1, 1'b1, 8'h24);
      do_rd(1, 1'b0, "data1_nostrobe");
      chk("hs1_read_no_strobe", C2O[1], 1'b1);
      do_wr(1, 1'b0, 8'h5A);
      chk("hs1_low", C2O[1], 1'b0);
      chk("po1", PO[15:8], 8'h5A);
      C1[1] = 1'b0;
      idle(LAT + 1);
      chk("hs1_hold", C2O[1], 1'b0);
      cyc();
      chk("hs1_release", C2O[1], 1'b1);
      m_cr[1][7] = 1'b1;
      C1[1] = 1'b1;
      idle(3);

      // pulse and static modes
      do_wr(0, 1'b1, 8'h2C);
      idle(1);
      chk("pulse_idle", C2O[0], 1'b1);
      do_rd(0, 1'b0, "data0_pulse");
      chk("pulse_low", C2O[0], 1'b0);
      cyc();
      chk("pulse_one_cycle", C2O[0], 1'b1);
      do_wr(0, 1'b1, 8'h34);
      idle(1);
      chk("static_low", C2O[0], 1'b0);
      do_wr(0, 1'b1, 8'h3C);
      idle(1);
      chk("static_high", C2O[0], 1'b1);

      // randomized register traffic against the model
      for (int i = 0; i < 64; i++) begin
         int ch;
         bit rs;
         if (i % 16 == 0) begin
            set_pins(24'($urandom));
            idle(3);
         end
         ch = int'($urandom_range(0, 3));
         rs = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) do_wr(ch, rs, 8'($urandom));
         else do_rd(ch, rs, "rand_read");
      end
      for (int i = 0; i < NP; i++) begin
         chk("rand_po", PO[i*W +: W], m_or[i]);
         chk("rand_po_oe", PO_OE[i*W +: W], m_ddr[i]);
      end

      // reset in the middle of a handshake
      do_wr(0, 1'b1, 8'h24);
      do_rd(0, 1'b0, "data0_prerst");
      chk("prerst_low", C2O[0], 1'b0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_async_c2o", C2O[0], 1'b1);
      chk("rst_async_po", PO, 24'h0);
      chk("rst_async_oe", C2_OE, 3'b000);
      model_reset();
      cyc();
      rst = 1'b0;
      do_rd(0, 1'b1, "cr0_after_rst");
      do_rd(3, 1'b0, "oor_data");
      do_rd(3, 1'b1, "oor_cr");

      idle(3);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
